// File: rtl/pq_sort_reg.sv
// Register-based sorted priority queue: slot 0 always holds the minimum key,
// ties leave in arrival order. Enqueue, dequeue, or both in one cycle.
module pq_sort_reg #(
  parameter int KW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq,
  input  logic [KW-1:0]              key_in,
  input  logic [DW-1:0]              data_in,
  input  logic                       deq,
  output logic [KW-1:0]              key_out,
  output logic [DW-1:0]              data_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][KW-1:0] key_q, key_n, key_dn, key_up;
  logic [DEPTH-1:0][DW-1:0] data_q, data_n, data_dn, data_up;
  logic [DEPTH-1:0]         vld_q, vld_n;
  logic [CW-1:0]            count_q, count_n;
  logic                     ovf_q, udf_q;
  logic [CW-1:0]            pos, ins_at;
  logic                     mode_ins, mode_del, mode_rep;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign key_out  = key_q[0];
  assign data_out = data_q[0];
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

  // Whole-array shifts; invalid slots hold zero so zeros shift in.
  assign key_dn  = {key_q[DEPTH-2:0], {KW{1'b0}}};
  assign data_dn = {data_q[DEPTH-2:0], {DW{1'b0}}};
  assign key_up  = {{KW{1'b0}}, key_q[DEPTH-1:1]};
  assign data_up = {{DW{1'b0}}, data_q[DEPTH-1:1]};

  // Entries with key <= key_in stay ahead of the new one (FIFO among ties).
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (key_q[i] <= key_in)) pos = pos + 1'b1;
    end
  end

  assign mode_ins = enq && ((!deq && !full) || (deq && empty));
  assign mode_del = deq && !enq && !empty;
  assign mode_rep = enq && deq && !empty;
  assign ins_at   = (mode_rep && (pos != '0)) ? pos - 1'b1 : pos;

  // Replace = drop head and insert: slots before the insert point move up,
  // slots after it end up where they started.
  always_comb begin
    key_n   = key_q;
    data_n  = data_q;
    count_n = count_q;
    vld_n   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mode_ins) begin
        if (CW'(i) == ins_at) begin
          key_n[i]  = key_in;
          data_n[i] = data_in;
        end else if (CW'(i) > ins_at) begin
          key_n[i]  = key_dn[i];
          data_n[i] = data_dn[i];
        end
      end else if (mode_del) begin
        key_n[i]  = key_up[i];
        data_n[i] = data_up[i];
      end else if (mode_rep) begin
        if (CW'(i) < ins_at) begin
          key_n[i]  = key_up[i];
          data_n[i] = data_up[i];
        end else if (CW'(i) == ins_at) begin
          key_n[i]  = key_in;
          data_n[i] = data_in;
        end
      end
    end
    if (mode_ins)      count_n = count_q + 1'b1;
    else if (mode_del) count_n = count_q - 1'b1;
    for (int i = 0; i < DEPTH; i++) vld_n[i] = (CW'(i) < count_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      data_q  <= '0;
      vld_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      key_q   <= key_n;
      data_q  <= data_n;
      vld_q   <= vld_n;
      count_q <= count_n;
      ovf_q   <= ovf_q | (enq & ~deq & full);
      udf_q   <= udf_q | (deq & empty);
    end
  end

endmodule

// File: tb/tb_pq_sort_reg.sv
// Scoreboarded bench for pq_sort_reg: directed scenarios plus random traffic
// against a sorted-list reference model.
module tb_pq_sort_reg;
  localparam int KW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq = 1'b0, deq = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic [DW-1:0] data_in = '0;
  logic [KW-1:0] key_out;
  logic [DW-1:0] data_out;
  logic          empty, full, ovf, udf;
  logic [CW-1:0] count;

  pq_sort_reg #(.KW(KW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enq(enq), .key_in(key_in), .data_in(data_in),
    .deq(deq), .key_out(key_out), .data_out(data_out), .empty(empty),
    .full(full), .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    int k, d, cnt, f, e, o, u;
  } exp_t;

  ent_t mq[$];
  bit   m_ovf = 0, m_udf = 0;
  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_ins(input logic [KW-1:0] k, input logic [DW-1:0] d);
    int idx = 0;
    ent_t en;
    en.k = k;
    en.d = d;
    foreach (mq[j]) if (mq[j].k <= k) idx = j + 1;
    mq.insert(idx, en);
  endtask

  task automatic model_step(input bit e, input bit d, input logic [KW-1:0] k,
                            input logic [DW-1:0] dt);
    exp_t x;
    if (e && d) begin
      if (mq.size() == 0) m_udf = 1;
      else void'(mq.pop_front());
      model_ins(k, dt);
    end else if (e) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else model_ins(k, dt);
    end else if (d) begin
      if (mq.size() == 0) m_udf = 1;
      else void'(mq.pop_front());
    end
    x.k   = (mq.size() > 0) ? int'(mq[0].k) : 0;
    x.d   = (mq.size() > 0) ? int'(mq[0].d) : 0;
    x.cnt = mq.size();
    x.f   = (mq.size() == DEPTH);
    x.e   = (mq.size() == 0);
    x.o   = m_ovf;
    x.u   = m_udf;
    exp_q.push_back(x);
  endtask

  task automatic cycle(input bit e, input bit d, input logic [KW-1:0] k,
                       input logic [DW-1:0] dt);
    @(negedge clk);
    enq = e; deq = d; key_in = k; data_in = dt;
    model_step(e, d, k, dt);
  endtask

  task automatic settle();
    cycle(0, 0, '0, '0);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_udf"}, int'(udf), 0);
    chk({tag, "_key"}, int'(key_out), 0);
    chk({tag, "_data"}, int'(data_out), 0);
  endtask

  // Monitor: each cycle the DUT presents new state one edge after stimulus
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("sb_key", int'(key_out), x.k);
      chk("sb_data", int'(data_out), x.d);
      chk("sb_count", int'(count), x.cnt);
      chk("sb_full", int'(full), x.f);
      chk("sb_empty", int'(empty), x.e);
      chk("sb_ovf", int'(ovf), x.o);
      chk("sb_udf", int'(udf), x.u);
    end
  end

  initial begin
    int ek[4] = '{2, 2, 5, 7};
    int ed[4] = '{8'hB, 8'hD, 8'hA, 8'hC};
    int pe, guard;

    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // underflow then enq+deq on empty
    cycle(0, 1, '0, '0);
    settle();
    chk("udf_set", int'(udf), 1);
    chk("udf_empty", int'(empty), 1);
    cycle(1, 1, 4'd3, 8'h33);
    settle();
    chk("ed_empty_count", int'(count), 1);
    chk("ed_empty_key", int'(key_out), 3);
    cycle(0, 1, '0, '0);

    // tie ordering
    cycle(1, 0, 4'd5, 8'hA);
    cycle(1, 0, 4'd2, 8'hB);
    cycle(1, 0, 4'd7, 8'hC);
    cycle(1, 0, 4'd2, 8'hD);
    settle();
    chk("tie_count", int'(count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("tie_key", int'(key_out), ek[i]);
      chk("tie_data", int'(data_out), ed[i]);
      cycle(0, 1, '0, '0);
      settle();
    end
    chk("tie_drained", int'(empty), 1);

    // replace in the middle
    cycle(1, 0, 4'd1, 8'h01);
    cycle(1, 0, 4'd4, 8'h04);
    cycle(1, 0, 4'd9, 8'h09);
    cycle(1, 1, 4'd6, 8'h06);
    settle();
    chk("rep_key", int'(key_out), 4);
    chk("rep_count", int'(count), 3);
    for (int i = 0; i < 3; i++) cycle(0, 1, '0, '0);

    // fill, overflow, replace while full
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, KW'(i + 3), DW'(8'h40 + i));
    cycle(1, 0, 4'd0, 8'hEE);
    settle();
    chk("full_flag", int'(full), 1);
    chk("full_count", int'(count), DEPTH);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_head", int'(key_out), 3);
    cycle(1, 1, 4'd0, 8'hFF);
    settle();
    chk("full_rep_key", int'(key_out), 0);
    chk("full_rep_count", int'(count), DEPTH);

    // asynchronous reset between edges with 5 entries stored
    for (int i = 0; i < 3; i++) cycle(0, 1, '0, '0);
    settle();
    chk("pre_rst_count", int'(count), 5);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_state("async");
    enq = 1'b1; deq = 1'b0; key_in = 4'd1; data_in = 8'h11;
    @(posedge clk);
    #1;
    chk("rst_hold_count", int'(count), 0);
    @(negedge clk);
    enq = 1'b0;
    rst = 1'b0;
    mq.delete();
    m_ovf = 0;
    m_udf = 0;

    // random traffic with phases biased toward full, empty and balanced
    pe = 50;
    for (int n = 0; n < 10000; n++) begin
      if (n % 500 == 0) begin
        case ((n / 500) % 3)
          0: pe = 80;
          1: pe = 20;
          default: pe = 50;
        endcase
      end
      cycle($urandom_range(99) < pe, $urandom_range(99) >= pe - 10,
            KW'($urandom_range(15)), DW'($urandom));
    end
    cycle(0, 0, '0, '0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
